// File: rtl/rr_encoder_4to2_pkg.sv
// Shared sizing and helpers for the 4-to-2 request encoder.
package rr_encoder_4to2_pkg;

   localparam int N_REQ  = 4;
   localparam int CODE_W = 2;

   function automatic logic popcount_gt1(input logic [N_REQ-1:0] req);
      logic seen;
      logic gt1;
      seen = 1'b0;
      gt1  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) begin
            if (seen) gt1 = 1'b1;
            seen = 1'b1;
         end
      end
      return gt1;
   endfunction

endpackage

// File: rtl/rr_encoder_4to2_if.sv
// Request/code handshake bundle between requester side and the encoder.
interface rr_encoder_4to2_if
   import rr_encoder_4to2_pkg::*;
#(
   parameter int N = N_REQ,
   parameter int W = CODE_W
);
   logic         en;
   logic [N-1:0] req;
   logic         ready;
   logic [W-1:0] code;
   logic         valid;
   logic         multi;

   modport master (output en, output req, output ready,
                   input  code, input valid, input multi);
   modport slave  (input  en, input req, input ready,
                   output code, output valid, output multi);
endinterface

// File: rtl/rr_encoder_4to2_rr_pick.sv
// Combinational request picker: fixed lowest-index or round-robin from a start pointer.
module rr_pick
   import rr_encoder_4to2_pkg::*;
#(
   parameter int N = N_REQ,
   parameter int W = CODE_W
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   input  logic         i_rr_en,
   output logic [W-1:0] o_sel,
   output logic         o_any
);
   logic [N-1:0]   w_mask;
   logic [2*N-1:0] w_dbl;
   logic [W-1:0]   w_sel;

   // Lower half keeps only requests at or above ptr; upper half is the full
   // vector, so the lowest hit in the doubled word is the wrapped search result.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_mask[i] = !i_rr_en || (W'(i) >= i_ptr);
      end
      w_dbl = {i_req, i_req & w_mask};
      w_sel = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (w_dbl[i]) w_sel = W'(i);
      end
   end

   assign o_sel = w_sel;
   assign o_any = |i_req;
endmodule

// File: rtl/rr_encoder_4to2.sv
// Registered 4-to-2 request encoder with valid/ready output and optional round-robin.
module rr_encoder_4to2
   import rr_encoder_4to2_pkg::*;
#(
   parameter int N  = N_REQ,
   parameter int W  = CODE_W,
   parameter int RR = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rr_encoder_4to2_if.slave     bus
);
   logic [W-1:0] r_code;
   logic [W-1:0] r_ptr;
   logic         r_valid;
   logic         r_multi;
   logic [W-1:0] w_sel;
   logic         w_any;
   logic         w_acc;

   rr_pick #(.N(N), .W(W)) u_pick (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .i_rr_en (RR != 0),
      .o_sel   (w_sel),
      .o_any   (w_any)
   );

   // A new capture may replace a pending code only when it is consumed this edge.
   assign w_acc = bus.en & w_any & (~r_valid | bus.ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code  <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
      end else if (w_acc) begin
         r_code  <= w_sel;
         r_multi <= popcount_gt1(bus.req);
         r_valid <= 1'b1;
         if (RR != 0) r_ptr <= w_sel + W'(1);
      end else if (bus.ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.code  = r_code;
   assign bus.valid = r_valid;
   assign bus.multi = r_multi;
endmodule

// File: tb/tb_rr_encoder_4to2.sv
// Directed bench: one fixed-priority and one round-robin encoder driven in lockstep.
module tb_rr_encoder_4to2;
   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic       ready;
   int         n_checks;
   int         n_fails;

   rr_encoder_4to2_if #(.N(4), .W(2)) b0 ();
   rr_encoder_4to2_if #(.N(4), .W(2)) b1 ();

   assign b0.en = en;  assign b0.req = req;  assign b0.ready = ready;
   assign b1.en = en;  assign b1.req = req;  assign b1.ready = ready;

   rr_encoder_4to2 #(.N(4), .W(2), .RR(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   rr_encoder_4to2 #(.N(4), .W(2), .RR(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; req = 4'b0000; ready = 1'b0;
      #12;
      n_checks++;
      if ({b0.valid, b0.code, b0.multi, b1.valid, b1.code, b1.multi} !== 8'b0) begin
         $display("FAIL reset_init act=%b exp=00000000",
                  {b0.valid, b0.code, b0.multi, b1.valid, b1.code, b1.multi});
         n_fails++;
      end
      rst_n = 1'b1;
      step();
      en = 1'b1; req = 4'b0110; ready = 1'b0;
      step();
      n_checks++;
      if (b1.valid !== 1'b1 || b1.code !== 2'd1 || b1.multi !== 1'b1) begin
         $display("FAIL reset_precapture act=v%b c%0d m%b exp=v1 c1 m1", b1.valid, b1.code, b1.multi);
         n_fails++;
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({b0.valid, b0.code, b0.multi, b1.valid, b1.code, b1.multi} !== 8'b0) begin
         $display("FAIL reset_async act=%b exp=00000000",
                  {b0.valid, b0.code, b0.multi, b1.valid, b1.code, b1.multi});
         n_fails++;
      end
      n_checks++;
      if (dut1.r_ptr !== 2'd0) begin
         $display("FAIL reset_ptr act=%0d exp=0", dut1.r_ptr);
         n_fails++;
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [3:0] vec [4];
      vec[0] = 4'b0001; vec[1] = 4'b0010; vec[2] = 4'b0100; vec[3] = 4'b1000;
      en = 1'b1; ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req = vec[i];
         step();
         n_checks++;
         if (b0.code !== 2'(i) || b0.valid !== 1'b1 || b0.multi !== 1'b0 ||
             b1.code !== 2'(i) || b1.valid !== 1'b1 || b1.multi !== 1'b0) begin
            $display("FAIL single_%0d act=c%0d/%0d v%b/%b m%b/%b exp=c%0d v1 m0", i,
                     b0.code, b1.code, b0.valid, b1.valid, b0.multi, b1.multi, i);
            n_fails++;
         end
      end
   endtask

   task automatic test_fixed();
      en = 1'b1; ready = 1'b1; req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (b0.code !== 2'd1 || b0.valid !== 1'b1 || b0.multi !== 1'b1) begin
            $display("FAIL fixed_%0d act=c%0d v%b m%b exp=c1 v1 m1", i, b0.code, b0.valid, b0.multi);
            n_fails++;
         end
      end
   endtask

   task automatic test_back_to_back_rr();
      logic [1:0] exp_rr [5];
      exp_rr[0] = 2'd0; exp_rr[1] = 2'd1; exp_rr[2] = 2'd2; exp_rr[3] = 2'd3; exp_rr[4] = 2'd0;
      // Capturing index 3 wraps the round-robin pointer to 0.
      en = 1'b1; ready = 1'b1; req = 4'b1000;
      step();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (b1.code !== exp_rr[i] || b1.valid !== 1'b1 || b1.multi !== 1'b1) begin
            $display("FAIL rr_%0d act=c%0d v%b m%b exp=c%0d v1 m1", i, b1.code, b1.valid, b1.multi, exp_rr[i]);
            n_fails++;
         end
         n_checks++;
         if (b0.code !== 2'd0 || b0.multi !== 1'b1) begin
            $display("FAIL rr_fixed_%0d act=c%0d m%b exp=c0 m1", i, b0.code, b0.multi);
            n_fails++;
         end
      end
   endtask

   task automatic test_stall();
      en = 1'b1; ready = 1'b1; req = 4'b0100;
      step();
      n_checks++;
      if (b1.code !== 2'd2 || b1.valid !== 1'b1 || dut1.r_ptr !== 2'd3) begin
         $display("FAIL stall_setup act=c%0d v%b p%0d exp=c2 v1 p3", b1.code, b1.valid, dut1.r_ptr);
         n_fails++;
      end
      ready = 1'b0; req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (b1.code !== 2'd2 || b1.valid !== 1'b1 || b1.multi !== 1'b0 || dut1.r_ptr !== 2'd3 ||
             b0.code !== 2'd2 || b0.valid !== 1'b1) begin
            $display("FAIL stall_%0d act=c%0d/%0d v%b/%b p%0d exp=c2 v1 p3", i,
                     b0.code, b1.code, b0.valid, b1.valid, dut1.r_ptr);
            n_fails++;
         end
      end
      ready = 1'b1;
      step();
      n_checks++;
      if (b1.code !== 2'd0 || b1.valid !== 1'b1 || b0.code !== 2'd0 || dut1.r_ptr !== 2'd1) begin
         $display("FAIL stall_release act=c%0d/%0d v%b p%0d exp=c0 v1 p1",
                  b0.code, b1.code, b1.valid, dut1.r_ptr);
         n_fails++;
      end
   endtask

   task automatic test_enable();
      en = 1'b1; ready = 1'b1; req = 4'b1000;
      step();
      en = 1'b0; ready = 1'b0; req = 4'b0100;
      step();
      n_checks++;
      if (b0.valid !== 1'b1 || b0.code !== 2'd3 || b1.valid !== 1'b1 || b1.code !== 2'd3) begin
         $display("FAIL en_hold act=v%b/%b c%0d/%0d exp=v1 c3", b0.valid, b1.valid, b0.code, b1.code);
         n_fails++;
      end
      ready = 1'b1;
      step();
      n_checks++;
      if (b0.valid !== 1'b0 || b0.code !== 2'd3 || b1.valid !== 1'b0 || b1.code !== 2'd3) begin
         $display("FAIL en_drain act=v%b/%b c%0d/%0d exp=v0 c3", b0.valid, b1.valid, b0.code, b1.code);
         n_fails++;
      end
      step();
      n_checks++;
      if (b0.valid !== 1'b0 || b1.valid !== 1'b0) begin
         $display("FAIL en_blocked act=v%b/%b exp=v0", b0.valid, b1.valid);
         n_fails++;
      end
      en = 1'b1; req = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (b0.valid !== 1'b0 || b0.code !== 2'd3 || b1.valid !== 1'b0 || b1.code !== 2'd3) begin
            $display("FAIL idle_%0d act=v%b/%b c%0d/%0d exp=v0 c3", i, b0.valid, b1.valid, b0.code, b1.code);
            n_fails++;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      test_reset();
      test_single();
      test_fixed();
      test_back_to_back_rr();
      test_stall();
      test_enable();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
